spi_pwm_regs: RTL

Clock-domain register bank and PWM generator that sits directly downstream of the SPI slave. It synchronises the slave's busy flag into clk and captures each completed 16-bit received word. It decodes the word as a register read/write and drives NUM_CH PWM outputs from shadowed period/duty registers. It also drives the slave's transmit word with read responses.

---
 rtl/spi_pwm_pkg.sv | 53 +++++
 rtl/spi_pwm_regs_pwm_core.sv | 66 ++++++
 rtl/spi_pwm_regs.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_pkg.sv
// -----------------------------------------------------------------------------
// spi_pwm_pkg
//   Shared definitions for the SPI-driven PWM register bank: word layout,
//   register address map, constant ID value and small helpers used by the
//   decoder.
// -----------------------------------------------------------------------------
package spi_pwm_pkg;

    // SPI word and register widths. The word layout below only works for
    // a 16-bit word carrying a 12-bit register payload.
    localparam int SPI_WORD_W = 16;
    localparam int REG_W      = 12;
    localparam int ADDR_W     = 3;

    // Bit positions inside a received word: [15]=W, [14:12]=addr, [11:0]=data.
    localparam int WORD_WR_BIT   = 15;
    localparam int WORD_ADDR_MSB = 14;
    localparam int WORD_ADDR_LSB = 12;
    localparam int WORD_DATA_MSB = 11;
    localparam int WORD_DATA_LSB = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    // Register address map. DUTY[ch] lives at ADDR_DUTY0 + ch.
    localparam reg_addr_t ADDR_PERIOD = 3'd0;
    localparam reg_addr_t ADDR_CTRL   = 3'd1;
    localparam reg_addr_t ADDR_DUTY0  = 3'd2;
    localparam reg_addr_t ADDR_ID     = 3'd7;

    localparam logic [REG_W-1:0] ID_VALUE = 12'hA5C;

    // CTRL bit that clears cmd_err when written as 1; always reads back 0.
    localparam int CTRL_ERRCLR_BIT = 11;

    // Decoded view of a received word; field order matches the bit layout.
    typedef struct packed {
        logic             wr;
        reg_addr_t        addr;
        logic [REG_W-1:0] data;
    } spi_word_t;

    // Address of the duty register for a given channel.
    function automatic reg_addr_t duty_addr(input int ch);
        return reg_addr_t'(int'(ADDR_DUTY0) + ch);
    endfunction

    // Read response word: MSB clear, echoed address, register value.
    function automatic logic [SPI_WORD_W-1:0] read_resp(input reg_addr_t        addr,
                                                        input logic [REG_W-1:0] value);
        return {1'b0, addr, value};
    endfunction

endpackage

// File: rtl/spi_pwm_regs_pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
//   Free-running PWM counter with shadow-to-active transfer and per-channel
//   compare. The counter runs 0..period_act and wraps; on the wrap edge the
//   active period and duty registers load from their shadows so a period is
//   never cut short or stretched by a mid-period write.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   period_sh      : shadow period (CNT_W)
//   duty_sh        : shadow duty per channel (NUM_CH x CNT_W)
//   en             : per-channel enable, applied without shadowing
//   pwm_out        : registered PWM outputs, one clk behind the counter
//   period_wrap    : one-clk pulse in the cycle after a wrap edge
// -----------------------------------------------------------------------------
module pwm_core #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 12
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [CNT_W-1:0]               period_sh,
    input  logic [NUM_CH-1:0][CNT_W-1:0]   duty_sh,
    input  logic [NUM_CH-1:0]              en,
    output logic [NUM_CH-1:0]              pwm_out,
    output logic                           period_wrap
);

    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             period_act;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_act;
    logic                         wrap;
    logic                         running;

    // With period_act == 0 the counter sits at 0, so wrap is true every clk
    // and the shadows flow straight through; that is the stopped state.
    assign wrap    = (cnt == period_act);
    assign running = (period_act != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            period_act  <= '0;
            duty_act    <= '0;
            pwm_out     <= '0;
            period_wrap <= 1'b0;
        end else begin
            if (wrap) begin
                cnt        <= '0;
                period_act <= period_sh;
                duty_act   <= duty_sh;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // No wrap pulses while stopped, otherwise it would fire every clk.
            period_wrap <= wrap & running;

            // duty 0 never satisfies cnt < duty; duty > period always does.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pwm_out[ch] <= en[ch] & running & (cnt < duty_act[ch]);
            end
        end
    end

endmodule

// File: rtl/spi_pwm_regs.sv
// -----------------------------------------------------------------------------
// spi_pwm_regs
//   Register bank sitting behind an SPI slave. The slave's busy flag is
//   brought into clk, each completed 16-bit word is decoded as a register
//   read or write, and NUM_CH PWM channels are driven from the shadowed
//   period/duty registers through pwm_core.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   spi_busy       : slave busy, high during a frame, asynchronous to clk
//   spi_rx         : last received word, stable between frame ends
//   spi_tx         : read response the slave latches at each frame end
//   pwm_out        : PWM outputs (NUM_CH)
//   period_wrap    : one-clk pulse per counter wrap
//   cmd_err        : sticky flag for bad address or a write to ID
//
// Frame hand-off: frame_done acts as a valid strobe for spi_rx with no ready
// side; the bank accepts every word in the cycle frame_done is high, so the
// slave only has to keep spi_rx stable until the next frame end.
// -----------------------------------------------------------------------------
module spi_pwm_regs
    import spi_pwm_pkg::*;
#(
    parameter int DATA_W = SPI_WORD_W,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = REG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_busy,
    input  logic [DATA_W-1:0] spi_rx,
    output logic [DATA_W-1:0] spi_tx,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_wrap,
    output logic              cmd_err
);

    // ------------------------------------------------------------------
    // Busy synchroniser and frame-end detect
    // ------------------------------------------------------------------
    logic busy_b1, busy_b2, busy_b3;
    logic frame_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_b1 <= 1'b0;
            busy_b2 <= 1'b0;
            busy_b3 <= 1'b0;
        end else begin
            busy_b1 <= spi_busy;
            busy_b2 <= busy_b1;
            busy_b3 <= busy_b2;
        end
    end

    // Falling edge of synchronised busy. Because the chain resets to 0, a
    // busy that is already low at reset release never produces a pulse.
    assign frame_done = busy_b3 & ~busy_b2;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]             period_sh;
    logic [NUM_CH-1:0][CNT_W-1:0] duty_sh;
    logic [NUM_CH-1:0]            en;

    // ------------------------------------------------------------------
    // Word decode (combinational, used only while frame_done is high)
    // ------------------------------------------------------------------
    spi_word_t          rx_word;
    logic               hit_period;
    logic               hit_ctrl;
    logic               hit_id;
    logic [NUM_CH-1:0]  duty_hit;
    logic [CNT_W-1:0]   duty_rd;
    logic               addr_mapped;
    logic [CNT_W-1:0]   rd_value;
    logic               err_set;
    logic               err_clr;

    assign rx_word    = spi_word_t'(spi_rx);
    assign hit_period = (rx_word.addr == ADDR_PERIOD);
    assign hit_ctrl   = (rx_word.addr == ADDR_CTRL);
    assign hit_id     = (rx_word.addr == ADDR_ID);

    // Duty decode by loop so no variable index can run past NUM_CH.
    always_comb begin
        duty_hit = '0;
        duty_rd  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rx_word.addr == duty_addr(ch)) begin
                duty_hit[ch] = 1'b1;
                duty_rd      = duty_sh[ch];
            end
        end
    end

    assign addr_mapped = hit_period | hit_ctrl | hit_id | (|duty_hit);

    // Read value; shadowed registers return their shadow copy, the CTRL
    // clear bit reads 0 and unmapped addresses return 0.
    always_comb begin
        rd_value = '0;
        if (hit_period) begin
            rd_value = period_sh;
        end else if (hit_ctrl) begin
            rd_value[NUM_CH-1:0] = en;
        end else if (hit_id) begin
            rd_value = ID_VALUE;
        end else if (|duty_hit) begin
            rd_value = duty_rd;
        end
    end

    // Unmapped access (read or write) and any write to ID flag an error.
    assign err_set = frame_done & (~addr_mapped | (rx_word.wr & hit_id));
    assign err_clr = frame_done & rx_word.wr & hit_ctrl & rx_word.data[CTRL_ERRCLR_BIT];

    // ------------------------------------------------------------------
    // Register writes, read response and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_sh <= '0;
            duty_sh   <= '0;
            en        <= '0;
            spi_tx    <= '0;
            cmd_err   <= 1'b0;
        end else begin
            if (frame_done) begin
                if (rx_word.wr) begin
                    if (hit_period) begin
                        period_sh <= rx_word.data;
                    end
                    if (hit_ctrl) begin
                        en <= rx_word.data[NUM_CH-1:0];
                    end
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (duty_hit[ch]) begin
                            duty_sh[ch] <= rx_word.data;
                        end
                    end
                end else begin
                    // Writes leave spi_tx holding the last read response.
                    spi_tx <= read_resp(rx_word.addr, rd_value);
                end
            end

            // A new error in the same cycle as a clear keeps the flag set.
            if (err_set) begin
                cmd_err <= 1'b1;
            end else if (err_clr) begin
                cmd_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM engine
    // ------------------------------------------------------------------
    pwm_core #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_pwm_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .period_sh   (period_sh),
        .duty_sh     (duty_sh),
        .en          (en),
        .pwm_out     (pwm_out),
        .period_wrap (period_wrap)
    );

endmodule
